module_divfrec_sched: RTL and testbench
=======================================

# module_divfrec_sched

Shared frequency-divider scheduler. Owns one divider counter running from the 27 MHz board clock and lets up to NREQ client blocks (keypad scan, display multiplex, debounce) request a new half-period `Nciclos` via a req/ack handshake. A round-robin arbiter grants one client at a time. The new value is applied glitch-free, only at a half-period boundary. It sits between the client blocks and everything clocked by the divided enable.

## Interface
- `NREQ`, 3: number of requesting clients (2..8)
- `W`, 24: width of `Nciclos` values
- `DEFAULT_N`, 13500: half-period loaded at reset (1 kHz output at 27 MHz)
- `clk`  in  1: system clock, 27 MHz
- `rst_n`  in  1: asynchronous, active-low reset
- `req_i`  in  NREQ: per-client request to load a new half-period
- `nciclos_i`  in  NREQ*W: per-client requested value; client k uses bits [k*W +: W]
- `ack_o`  out  NREQ: one-cycle pulse when the client's value has been applied
- `busy_o`  out  1: high while a grant is pending or being acknowledged
- `nciclos_o`  out  W: currently active half-period
- `tick_o`  out  1: one-cycle pulse at each half-period boundary
- `f_o`  out  1: divided square wave, period 2·`nciclos_o` cycles

## Operation
- Divider: `cnt` counts 0..N−1, where N = active value.
  - When `cnt==N−1`: `tick_o`=1, `cnt`←0, `f_o` toggles.
- The FSM has three states:
  - IDLE: if any `req_i` is high, the round-robin arbiter picks the first requester at or after `rr_ptr`. It latches the index and the value, then goes to PEND.
  - PEND: waits for the boundary cycle (`cnt==N−1`).
    - At the boundary: N←latched value, `cnt`←0, go to ACK.
    - If the granted `req_i` drops first: discard the grant, go to IDLE, no ack, `rr_ptr` unchanged.
  - ACK: `ack_o[g]`=1 for exactly one cycle, `rr_ptr`←g+1 mod NREQ, go to IDLE.
- Value clamp: a latched value below 2 is stored as 2. The value is captured at grant; later changes to `nciclos_i` are ignored.
- Clients must hold `req_i` and `nciclos_i` until `ack_o`, and drop `req_i` in the ack cycle.
  - If `req_i` is still high in IDLE, the request is re-arbitrated normally. Because `rr_ptr` has advanced, other pending clients win first.
- Simultaneous requests: exactly one grant. The rest wait, with no starvation (round-robin).
- The tick on the apply boundary belongs to the old N: `tick_o`=1 and `f_o` toggles in that cycle. The next tick comes N_new cycles later.

## Timing
- Reset values: `cnt`=0, N=`DEFAULT_N`, `f_o`=0, `tick_o`=0, `ack_o`=0, `busy_o`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-operation aborts any grant immediately; no ack is ever issued for it.
- Request latency:
  - Request seen in IDLE at cycle t → PEND and `busy_o`=1 from t+1.
  - Apply at the first boundary cycle b ≥ t+1.
  - `ack_o` at b+1; `busy_o` falls at b+2.
- A boundary occurring in the same cycle as the grant (cycle t) is not used; apply waits for the next one.
- `nciclos_o` changes at b+1. `tick_o` and `f_o` are registered.

## Structure
- Package `divfrec_pkg`:
  - FSM state enum `sched_state_t {IDLE, PEND, ACK}`
  - constants `DIV_W`=24, `DIV_DEFAULT_N`=13500, `DIV_MIN_N`=2
- One sub-module `module_rr_arb`: combinational round-robin priority pick from `req` and `rr_ptr`. Outputs `gnt_valid` and `gnt_idx`.
- Divider counter, FSM and value registers live in the top module.

## Test plan
- Reset: `DEFAULT_N`=4, no requests → `tick_o` every 4 cycles; `f_o` period 8 cycles, starting at 0; `nciclos_o`=4.
- Single request: client 1 requests 6 → ack one cycle after the next boundary; after that, ticks every 6 cycles and `nciclos_o`=6.
- Contention: clients 0, 1 and 2 request 5, 7 and 9 in the same cycle → acks in order 0, 1, 2. Each value is applied at a separate boundary; final `nciclos_o`=9.
- Clamp and withdraw:
  - Client 2 requests 0 → `nciclos_o`=2; `f_o` period 4.
  - Client 0 requests 10, then drops `req_i` during PEND → no ack; N is unchanged.
- Reset mid-PEND: `rst_n` pulsed low while busy → all outputs return to reset values, N=`DEFAULT_N`, no `ack_o` pulse.
- Held request: client 0 keeps `req_i` high after its ack while client 1 is requesting → client 1 is granted next.

Source files
------------

// File: rtl/divfrec_pkg.sv
// -----------------------------------------------------------------------------
// divfrec_pkg
// Shared types and constants for the frequency-divider scheduler.
//   sched_state_t : scheduler FSM states
//   DIV_W         : default width of half-period values
//   DIV_DEFAULT_N : half-period loaded at reset (1 kHz at 27 MHz)
//   DIV_MIN_N     : smallest half-period accepted; smaller requests are raised
//   idx_w()       : width needed to index n clients
// -----------------------------------------------------------------------------
package divfrec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK
    } sched_state_t;

    localparam int DIV_W         = 24;
    localparam int DIV_DEFAULT_N = 13500;
    localparam int DIV_MIN_N     = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/module_rr_arb.sv
// -----------------------------------------------------------------------------
// module_rr_arb
// Combinational round-robin pick: the first asserted request at or after
// rr_ptr (wrapping modulo NREQ) wins.
//   req       in  NREQ : request vector
//   rr_ptr    in  IW   : highest-priority index, always < NREQ
//   gnt_valid out 1    : some request is asserted
//   gnt_idx   out IW   : index of the winning request
// -----------------------------------------------------------------------------
module module_rr_arb
    import divfrec_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_idx
);

    int k;

    // Scan from the lowest priority offset down so the highest-priority hit
    // (offset 0 = rr_ptr) is the last assignment and therefore wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (req[IW'(k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/module_divfrec_sched.sv
// -----------------------------------------------------------------------------
// module_divfrec_sched
// Shared frequency divider with a req/ack scheduler. Clients request a new
// half-period; a round-robin arbiter grants one at a time and the value is
// applied only at a half-period boundary so f_o never glitches.
//   clk       in  1      : system clock (27 MHz)
//   rst_n     in  1      : asynchronous active-low reset
//   req_i     in  NREQ   : per-client load request
//   nciclos_i in  NREQ*W : per-client half-period, client k at [k*W +: W]
//   ack_o     out NREQ   : one-cycle pulse when the client's value is applied
//   busy_o    out 1      : grant pending or being acknowledged
//   nciclos_o out W      : active half-period
//   tick_o    out 1      : pulse in each half-period boundary cycle
//   f_o       out 1      : divided square wave, period 2*nciclos_o
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate among asserted requests
// PEND  | grant latched; wait for the next boundary or a withdrawal
// ACK   | value applied last cycle; pulse ack_o, advance rr pointer
// -----------------------------------------------------------------------------
module module_divfrec_sched
    import divfrec_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int W         = DIV_W,
    parameter int DEFAULT_N = DIV_DEFAULT_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] nciclos_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              busy_o,
    output logic [W-1:0]      nciclos_o,
    output logic              tick_o,
    output logic              f_o
);

    localparam int IW = idx_w(NREQ);

    sched_state_t    state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    n_q, n_d;
    logic [W-1:0]    val_q;
    logic [W-1:0]    req_val, req_clamped;
    logic [IW-1:0]   g_q, rr_ptr_q, gnt_idx;
    logic            gnt_valid;
    logic            boundary;
    logic            take;
    logic            apply;

    module_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req       (req_i),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign boundary    = (cnt_q == n_q - W'(1));
    assign req_val     = nciclos_i[int'(gnt_idx)*W +: W];
    assign req_clamped = (req_val < W'(DIV_MIN_N)) ? W'(DIV_MIN_N) : req_val;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    take    = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                // Withdrawal wins over a coincident boundary: the client no
                // longer vouches for the value it asked for.
                if (!req_i[g_q]) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    apply   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_o = '0;
        if (state_q == ACK) begin
            ack_o[g_q] = 1'b1;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign nciclos_o = n_q;

    assign cnt_d = boundary ? '0 : cnt_q + W'(1);
    assign n_d   = apply ? val_q : n_q;

    // tick_o is registered but predicted one cycle ahead from the next
    // count/period, so it is high exactly in the boundary cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_q      <= W'(DEFAULT_N);
            val_q    <= '0;
            g_q      <= '0;
            rr_ptr_q <= '0;
            tick_o   <= 1'b0;
            f_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            tick_o  <= (cnt_d == n_d - W'(1));
            f_o     <= f_o ^ boundary;
            if (take) begin
                g_q   <= gnt_idx;
                val_q <= req_clamped;
            end
            if (state_q == ACK) begin
                rr_ptr_q <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_module_divfrec_sched.sv
// -----------------------------------------------------------------------------
// tb_module_divfrec_sched
// Scoreboard bench: expected (client, value) pairs are queued when requests
// are driven and popped by a monitor whenever ack_o pulses.
// -----------------------------------------------------------------------------
module tb_module_divfrec_sched;

    localparam int NREQ = 3;
    localparam int W    = 24;
    localparam int DN   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_i = '0;
    logic [NREQ*W-1:0] nciclos_i = '0;
    logic [NREQ-1:0]   ack_o;
    logic              busy_o;
    logic [W-1:0]      nciclos_o;
    logic              tick_o;
    logic              f_o;

    always #5 clk = ~clk;

    module_divfrec_sched #(
        .NREQ      (NREQ),
        .W         (W),
        .DEFAULT_N (DN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .nciclos_i (nciclos_i),
        .ack_o     (ack_o),
        .busy_o    (busy_o),
        .nciclos_o (nciclos_o),
        .tick_o    (tick_o),
        .f_o       (f_o)
    );

    typedef struct {
        int idx;
        int val;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            e_mon;
    logic [NREQ-1:0] hold = '0;
    int              n_checks = 0;
    int              n_errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && ack_o != '0) begin
            if (sb_q.size() == 0) begin
                chk_val("unexp_ack", 32'(ack_o), 0);
            end else begin
                e_mon = sb_q.pop_front();
                chk_val("ack_idx", 32'(ack_o), 32'(1) << e_mon.idx);
                chk_val("ack_n", 32'(nciclos_o), e_mon.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input int k, input int v, input bit expect_ack);
        nciclos_i[k*W +: W] = W'(v);
        req_i[k] = 1'b1;
        if (expect_ack) sb_q.push_back('{idx: k, val: clampv(v)});
    endtask

    task automatic wait_ack(output int idx, input int budget);
        logic prev_tick;
        prev_tick = 1'b0;
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ack_o != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (ack_o[k] && idx < 0) idx = k;
                end
                chk_val("ack_after_tick", 32'(prev_tick), 1);
                if (!hold[idx]) req_i[idx] = 1'b0;
                break;
            end
            prev_tick = tick_o;
        end
        if (idx < 0) chk_val("ack_timeout", 0, 1);
    endtask

    task automatic tick_gap(output int gap);
        int c;
        gap = -1;
        c = 0;
        while (c < 64) begin
            @(negedge clk);
            c++;
            if (tick_o) break;
        end
        if (tick_o) begin
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk);
                if (tick_o) begin
                    gap = i;
                    break;
                end
            end
        end
    endtask

    task automatic f_period(output int per);
        logic p;
        int   c;
        per = -1;
        @(negedge clk);
        p = f_o;
        c = 0;
        while (c < 128) begin
            @(negedge clk);
            c++;
            if (f_o && !p) break;
            p = f_o;
        end
        if (c < 128) begin
            p = f_o;
            for (int i = 1; i <= 128; i++) begin
                @(negedge clk);
                if (f_o && !p) begin
                    per = i;
                    break;
                end
                p = f_o;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int idx;
        int gap;
        int per;

        // Reset values
        step(3);
        @(negedge clk);
        chk_val("rst_tick", 32'(tick_o), 0);
        chk_val("rst_f", 32'(f_o), 0);
        chk_val("rst_ack", 32'(ack_o), 0);
        chk_val("rst_busy", 32'(busy_o), 0);
        chk_val("rst_n", 32'(nciclos_o), DN);
        step(1);
        rst_n = 1'b1;
        tick_gap(gap);
        chk_val("rst_gap", gap, DN);
        f_period(per);
        chk_val("rst_fper", per, 2 * DN);

        // Contention: rr_ptr is 0, so clients are served 0, 1, 2
        step(1);
        drive_req(0, 5, 1'b1);
        drive_req(1, 7, 1'b1);
        drive_req(2, 9, 1'b1);
        wait_ack(idx, 100);
        chk_val("cont_first", idx, 0);
        wait_ack(idx, 100);
        chk_val("cont_second", idx, 1);
        wait_ack(idx, 100);
        chk_val("cont_third", idx, 2);
        step(1);
        tick_gap(gap);
        chk_val("cont_gap", gap, 9);
        chk_val("cont_n", 32'(nciclos_o), 9);

        // Single request with latency checks
        step(1);
        drive_req(1, 6, 1'b1);
        @(negedge clk);
        chk_val("single_busy_t", 32'(busy_o), 0);
        @(negedge clk);
        chk_val("single_busy_t1", 32'(busy_o), 1);
        wait_ack(idx, 100);
        chk_val("single_idx", idx, 1);
        chk_val("single_busy_ack", 32'(busy_o), 1);
        @(negedge clk);
        chk_val("single_busy_fall", 32'(busy_o), 0);
        tick_gap(gap);
        chk_val("single_gap", gap, 6);

        // Withdraw during PEND, right after a boundary so no apply can occur
        begin
            int c;
            c = 0;
            while (!tick_o && c < 64) begin
                @(negedge clk);
                c++;
            end
            chk_val("wd_sync", 32'(tick_o), 1);
        end
        step(1);
        drive_req(0, 10, 1'b0);
        step(1);
        req_i[0] = 1'b0;
        @(negedge clk);
        chk_val("wd_busy", 32'(busy_o), 1);
        step(20);
        @(negedge clk);
        chk_val("wd_idle", 32'(busy_o), 0);
        chk_val("wd_n", 32'(nciclos_o), 6);
        tick_gap(gap);
        chk_val("wd_gap", gap, 6);

        // Clamp: request 0 becomes 2
        step(1);
        drive_req(2, 0, 1'b1);
        wait_ack(idx, 100);
        chk_val("clamp_idx", idx, 2);
        step(1);
        tick_gap(gap);
        chk_val("clamp_gap", gap, 2);
        f_period(per);
        chk_val("clamp_fper", per, 4);
        chk_val("clamp_n", 32'(nciclos_o), 2);

        // Held request: client 0 stays high after its ack, client 1 goes next
        step(1);
        hold[0] = 1'b1;
        drive_req(0, 8, 1'b1);
        drive_req(1, 3, 1'b1);
        sb_q.push_back('{idx: 1, val: 3});
        sb_q.delete(sb_q.size() - 1);
        sb_q.push_back('{idx: 0, val: 8});
        wait_ack(idx, 100);
        chk_val("held_first", idx, 0);
        wait_ack(idx, 100);
        chk_val("held_next", idx, 1);
        hold[0] = 1'b0;
        wait_ack(idx, 100);
        chk_val("held_again", idx, 0);
        step(1);
        chk_val("held_n", 32'(nciclos_o), 8);

        // Reset while a grant is pending
        drive_req(1, 20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_val("rp_busy", 32'(busy_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("rp_busy_rst", 32'(busy_o), 0);
        chk_val("rp_ack_rst", 32'(ack_o), 0);
        chk_val("rp_tick_rst", 32'(tick_o), 0);
        chk_val("rp_f_rst", 32'(f_o), 0);
        chk_val("rp_n_rst", 32'(nciclos_o), DN);
        req_i[1] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(20);
        @(negedge clk);
        chk_val("rp_busy_after", 32'(busy_o), 0);
        chk_val("rp_n_after", 32'(nciclos_o), DN);
        tick_gap(gap);
        chk_val("rp_gap", gap, DN);

        chk_val("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
